// File: rtl/tiny_seq_decode.sv
// Fetch/decode/writeback sequencer driving an external 8-bit ADD/SUB ALU from a 4x8 register file.
// Latency: LDI 3 cycles, ADD/SUB 5 cycles, HALT 3 cycles to reach HALTED; imem read data expected one cycle after imem_en.
// Backpressure: none; instruction memory and ALU are fixed-latency, start is ignored unless idle.
module tiny_seq_decode #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [7:0]        operand_a,
    output logic [7:0]        operand_b,
    output logic              opcode,
    input  logic [7:0]        alu_result,
    output logic              busy,
    output logic              halted,
    input  logic [1:0]        dbg_sel,
    output logic [7:0]        dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [7:0]        rf_q [4];
    logic [7:0]        rf_d [4];
    logic [7:0]        operand_a_q, operand_a_d;
    logic [7:0]        operand_b_q, operand_b_d;
    logic              opcode_q, opcode_d;

    logic [1:0] op_f;
    logic [1:0] rd_f;
    logic [1:0] rs1_f;
    logic [1:0] rs2_f;
    logic [7:0] imm_f;

    assign op_f  = instr_q[15:14];
    assign rd_f  = instr_q[13:12];
    assign rs1_f = instr_q[11:10];
    assign rs2_f = instr_q[9:8];
    assign imm_f = instr_q[7:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        rf_d        = rf_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        opcode_d    = opcode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = START_ADDR;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                instr_d = imem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op_f)
                    OP_LDI: begin
                        rf_d[rd_f] = imm_f;
                        pc_d       = pc_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: begin
                        operand_a_d = rf_q[rs1_f];
                        operand_b_d = rf_q[rs2_f];
                        opcode_d    = op_f[0];
                        state_d     = S_EXEC;
                    end
                endcase
            end
            // ALU registers the operands at the end of EXEC; its result is valid in WB.
            S_EXEC: state_d = S_WB;
            S_WB: begin
                rf_d[rd_f] = alu_result;
                pc_d       = pc_q + ADDR_W'(1);
                state_d    = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= START_ADDR;
            instr_q     <= '0;
            rf_q        <= '{default: '0};
            operand_a_q <= '0;
            operand_b_q <= '0;
            opcode_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            rf_q        <= rf_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            opcode_q    <= opcode_d;
        end
    end

    assign imem_en   = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign opcode    = opcode_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted    = (state_q == S_HALTED);
    assign dbg_data  = rf_q[dbg_sel];

endmodule

// File: tb/tb_tiny_seq_decode.sv
// Bench for tiny_seq_decode: instruction-level reference model plus directed programs and random programs.
module tb_tiny_seq_decode;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata = '0;
    logic [7:0]    operand_a, operand_b;
    logic          opcode;
    logic [7:0]    alu_result = '0;
    logic          busy, halted;
    logic [1:0]    dbg_sel = '0;
    logic [7:0]    dbg_data;

    logic [15:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: mode 0 idle, 1 running, 2 halted; k = cycle within current instruction.
    int         m_mode = 0;
    logic [7:0] m_pc = '0;
    logic [7:0] m_rf [4];
    logic [7:0] m_a = '0, m_b = '0;
    logic       m_op = 1'b0;
    int         m_k = 0;
    bit         m_valid = 1'b0;

    tiny_seq_decode #(.ADDR_W(AW), .START_ADDR(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .opcode     (opcode),
        .alu_result (alu_result),
        .busy       (busy),
        .halted     (halted),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory and the registered ADD/SUB ALU.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        alu_result <= opcode ? (operand_a - operand_b) : (operand_a + operand_b);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update(input bit st, input bit rst);
        logic [15:0] ins;
        logic [1:0]  kind, rd, rs1, rs2;
        int          lat;
        if (rst) begin
            m_valid = 1'b1; m_mode = 0; m_pc = '0; m_rf = '{default: '0};
            m_a = '0; m_b = '0; m_op = 1'b0; m_k = 0;
            return;
        end
        if (!m_valid || m_mode == 2) return;
        if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_pc = '0; m_k = 0; end
            return;
        end
        ins  = mem[m_pc];
        kind = ins[15:14]; rd = ins[13:12]; rs1 = ins[11:10]; rs2 = ins[9:8];
        lat  = (kind < 2'd2) ? 5 : 3;
        if (m_k == 2) begin
            if (kind == 2'd2) m_rf[rd] = ins[7:0];
            else if (kind == 2'd3) begin m_mode = 2; return; end
            else begin m_a = m_rf[rs1]; m_b = m_rf[rs2]; m_op = kind[0]; end
        end
        if (m_k == lat - 1) begin
            if (kind < 2'd2)
                m_rf[rd] = kind[0] ? (m_rf[rs1] - m_rf[rs2]) : (m_rf[rs1] + m_rf[rs2]);
            m_pc = m_pc + 8'd1;
            m_k  = 0;
        end else begin
            m_k++;
        end
    endtask

    // One clock: drive inputs on the falling edge, compare every output against the model, advance model.
    task automatic step(input bit st, input bit rst, input int dsel = -1);
        @(negedge clk);
        start   = st;
        reset   = rst;
        dbg_sel = (dsel < 0) ? 2'($urandom_range(0, 3)) : 2'(dsel);
        #1;
        cyc++;
        if (m_valid) begin
            check("imem_en",   imem_en,   (m_mode == 1) && (m_k == 0));
            check("imem_addr", imem_addr, m_pc);
            check("busy",      busy,      m_mode == 1);
            check("halted",    halted,    m_mode == 2);
            check("operand_a", operand_a, m_a);
            check("operand_b", operand_b, m_b);
            check("opcode",    opcode,    m_op);
            check("dbg_data",  dbg_data,  m_rf[dbg_sel]);
        end
        model_update(st, rst);
    endtask

    task automatic load4(input logic [15:0] w0, w1, w2, w3);
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    task automatic check_rf(input string tag, input logic [7:0] e0, e1, e2, e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int r = 0; r < 4; r++) begin
            step(1'b0, 1'b0, r);
            check($sformatf("%s_rf%0d", tag, r), dbg_data, e[r]);
        end
    endtask

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        step(0, 1); step(0, 1); step(0, 0);
        check("reset_busy", busy, 1'b0);
        check("reset_imem_en", imem_en, 1'b0);
        check("reset_addr", imem_addr, 8'h00);

        // LDI/ADD program, with a start pulse in cycle 5 that must be ignored.
        load4(16'h9005, 16'hA003, 16'h3600, 16'hC000);
        step(0, 1);
        step(1, 0);
        for (int i = 1; i <= 16; i++) begin
            step(i == 5, 0);
            if (i == 1)  check("t1_busy1", busy, 1'b1);
            if (i == 10) begin
                check("t1_exec_a", operand_a, 8'd5);
                check("t1_exec_b", operand_b, 8'd3);
                check("t1_exec_op", opcode, 1'b0);
            end
            if (i == 14) begin
                check("t1_busy14", busy, 1'b1);
                check("t1_nohalt14", halted, 1'b0);
            end
            if (i == 15) check("t1_halt15", halted, 1'b1);
        end
        check_rf("t1", 8'd0, 8'd5, 8'd3, 8'd8);
        step(1, 0); step(0, 0);
        check("t1_start_ignored", halted, 1'b1);
        check("t1_halt_pc", imem_addr, 8'h03);

        // SUB with wraparound into R0.
        load4(16'h9003, 16'hA005, 16'h4600, 16'hC000);
        step(0, 1);
        step(1, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0);
            if (i == 10) check("t2_exec_op", opcode, 1'b1);
        end
        check_rf("t2", 8'hFE, 8'd3, 8'd5, 8'd0);

        // Dependent chain: writeback must land before the next read.
        load4(16'h9001, 16'h3500, 16'h3D00, 16'hC000);
        step(0, 1);
        step(1, 0);
        for (int i = 1; i <= 20; i++) step(0, 0);
        check("t3_halted", halted, 1'b1);
        check_rf("t3", 8'd0, 8'd1, 8'd0, 8'd3);

        // Reset asserted during EXEC of the ADD, then a clean re-run.
        load4(16'h9005, 16'hA003, 16'h3600, 16'hC000);
        step(0, 1);
        step(1, 0);
        for (int i = 1; i <= 10; i++) step(0, i == 10);
        check("t4_in_exec", operand_a, 8'd5);
        step(0, 0);
        check("t4_busy", busy, 1'b0);
        check("t4_halted", halted, 1'b0);
        check("t4_imem_en", imem_en, 1'b0);
        check("t4_op_a", operand_a, 8'd0);
        check("t4_op_b", operand_b, 8'd0);
        check("t4_addr", imem_addr, 8'h00);
        check_rf("t4", 8'd0, 8'd0, 8'd0, 8'd0);
        step(1, 0);
        for (int i = 1; i <= 15; i++) step(0, 0);
        check("t4_rerun_halt", halted, 1'b1);
        check_rf("t4r", 8'd0, 8'd5, 8'd3, 8'd8);

        // PC wrap: every address holds LDI R1,(addr+1); the program never halts.
        for (int i = 0; i < 256; i++) mem[i] = {8'h91, 8'(i + 1)};
        step(0, 1);
        step(1, 0);
        for (int i = 1; i <= 775; i++) begin
            step(0, 0, (i == 772) ? 1 : -1);
            if (i == 766) check("t5_addr255", imem_addr, 8'hFF);
            if (i == 769) begin
                check("t5_wrap_addr", imem_addr, 8'h00);
                check("t5_wrap_en", imem_en, 1'b1);
            end
            if (i == 772) check("t5_rf1_after_wrap", dbg_data, 8'd1);
        end

        // Random programs with occasional stray starts and resets.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[15:14] == 2'b11 && $urandom_range(0, 39) != 0)
                    w[15:14] = 2'($urandom_range(0, 2));
                mem[i] = w;
            end
            step(0, 1);
            for (int i = 0; i < 400; i++)
                step($urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tiny_seq_decode.md
Name: tiny_seq_decode

Overview:
Fetch/decode/writeback sequencer that sits directly upstream of the 8-bit ADD/SUB ALU stage, `cpu`.
- Fetches 16-bit instructions from a synchronous instruction memory and decodes them.
- Holds a 4x8-bit register file and drives operand_a/operand_b/opcode into the ALU.
- Writes the ALU's registered result back into the register file.
- Turns the ALU into a minimal programmable core; shares clk/reset with the ALU.

Parameters:
ADDR_W, 8, width of instruction-memory address / program counter
START_ADDR, 0, PC value loaded on reset and on each accepted start

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  single-cycle pulse, begins execution from START_ADDR when idle
imem_en  output  1  instruction-memory read enable
imem_addr  output  ADDR_W  instruction-memory read address
imem_rdata  input  16  instruction data, valid the cycle after imem_en
operand_a  output  8  ALU operand A (registered)
operand_b  output  8  ALU operand B (registered)
opcode  output  1  ALU op, 0=ADD, 1=SUB (registered)
alu_result  input  8  registered ALU result
busy  output  1  high in any state except IDLE/HALTED
halted  output  1  high in HALTED
dbg_sel  input  2  register-file debug read select
dbg_data  output  8  combinational read of rf[dbg_sel]

Behaviour:
- Reset is synchronous, active-high: one clock, reset=1 at rising edge.
- Reset values: state=IDLE, pc=START_ADDR, rf[0..3]=0, instr=0, operand_a=0, operand_b=0, opcode=0, imem_en=0, busy=0, halted=0.
- Reset mid-operation aborts immediately to the reset state; no partial writeback.
- Instruction format: [15:14] op (00 ADD, 01 SUB, 10 LDI, 11 HALT), [13:12] rd, [11:10] rs1, [9:8] rs2, [7:0] imm. Unused fields are ignored.
- All four registers are general purpose; R0 is writable.
- FSM states: IDLE, FETCH, WAIT, DECODE, EXEC, WB, HALTED.
- IDLE: when start=1, go to FETCH with pc=START_ADDR. Otherwise stay.
- FETCH: imem_en=1, imem_addr=pc, both combinational from state/pc. Go to WAIT.
- imem_en is 0 in every other state. imem_addr=pc at all times.
- WAIT: instr<=imem_rdata; go to DECODE.
- DECODE, by instr[15:14]:
  - LDI: rf[rd]<=imm; pc<=pc+1; go to FETCH.
  - ADD/SUB: operand_a<=rf[rs1]; operand_b<=rf[rs2]; opcode<=instr[14]; go to EXEC.
  - HALT: go to HALTED; pc is not incremented.
- EXEC: operands are stable; the ALU samples them at the end of this cycle. Go to WB.
- WB: rf[rd]<=alu_result; pc<=pc+1; go to FETCH.
- HALTED: halted=1; only reset leaves this state. start is ignored.
- operand_a/operand_b/opcode hold their last value outside DECODE updates.
- Latency per instruction: LDI 3 cycles, ADD/SUB 5 cycles, HALT 3 cycles to enter HALTED.
- PC increments modulo 2^ADDR_W: all-ones wraps to 0.
- start while busy or halted is ignored.
- Register-file write and read of the same register in one cycle: the read sees the old value. This cannot occur in the sequence; document only.
- dbg_data is a pure combinational read and has no side effects.

Test Plan:
- LDI/ADD: imem = {0x9005 (LDI R1,5), 0xA003 (LDI R2,3), 0x3600 (ADD R3,R1,R2), 0xC000 (HALT)}; start pulse in cycle 0. Required: halted=1 in cycle 15; rf = {0,5,3,8}; operand_a=5, operand_b=3, opcode=0 during EXEC; busy=1 in cycles 1-14.
- SUB wrap: {0x9003 (LDI R1,3), 0xA005 (LDI R2,5), 0x4600 (SUB R0,R1,R2), 0xC000}. Required: rf[0]=0xFE; opcode=1 during EXEC.
- Dependent chain: {0x9001 (LDI R1,1), 0x3500 (ADD R3,R1,R1), 0x3D00 (ADD R3,R3,R1), 0xC000}. Required: rf[3]=3, which proves writeback precedes the next read.
- PC wrap: ADDR_W=2, imem={0x9001, 0x9102 (LDI R1,2), 0x9103 (LDI R1,3), 0x9104 (LDI R1,4)}, never halts. Required: imem_addr sequence 0,1,2,3,0,…; rf[1] cycles 1→2→3→4→1.
- Ignored start: pulse start in cycle 5 and after HALTED. Required: pc and sequence unaffected; halted stays 1.
- Reset mid-ADD: assert reset during EXEC for one cycle. Required: next cycle state=IDLE, all rf=0, operands=0, imem_en=0, busy=0, halted=0; a subsequent start re-runs from START_ADDR.
